// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the bin2bcd_seq converter
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    // Active-high glyphs, bit order gfedcba
    localparam logic [SEG_W-1:0] SEG_0   = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle for bin2bcd_seq (seg only with BIN2BCD_7SEG_EN)
interface bin2bcd_seq_if #(
    parameter int N = 4,
    parameter int D = 2
);
    import bcd_pkg::*;

    logic                       start;
    logic [N-1:0]               bin;
    logic                       busy;
    logic                       done;
    logic [DIGIT_W*D-1:0]       bcd;
    logic [$clog2(N+1)-1:0]     count;
`ifdef BIN2BCD_7SEG_EN
    logic [SEG_W*D-1:0]         seg;

    modport master (output start, bin, input busy, done, bcd, count, seg);
    modport slave  (input start, bin, output busy, done, bcd, count, seg);
`else
    modport master (output start, bin, input busy, done, bcd, count);
    modport slave  (input start, bin, output busy, done, bcd, count);
`endif

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - single BCD digit adjust cell: values >= 5 get +3
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] in_i,
    output logic [DIGIT_W-1:0] out_o
);

    // Inputs never exceed 9, so the 4-bit sum cannot wrap
    always_comb begin
        out_o = in_i;
        if (in_i >= 4'd5) begin
            out_o = in_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - one-bit-per-clock shift-and-add-3 binary to BCD converter; BIN2BCD_7SEG_EN adds seg decode
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int N = 4,
    parameter int D = 2
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int BCD_W = DIGIT_W * D;
    localparam int CNT_W = $clog2(N + 1);
    localparam int WIDE_W = BCD_W + N;

    generate
        if ((10 ** D) <= ((2 ** N) - 1)) begin : g_cfg_err
            $error("bin2bcd_seq: D too small to hold 2**N-1");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [N-1:0]       sh_q, sh_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   acc_adj;
    logic [WIDE_W-1:0]  wide_shift;

    generate
        for (genvar g = 0; g < D; g++) begin : g_digit
            bcd_add3 u_add3 (
                .in_i  (acc_q[g*DIGIT_W +: DIGIT_W]),
                .out_o (acc_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Carry out of the top digit falls off the left end of the shift
    assign wide_shift = {acc_adj, sh_q} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sh_d    = bus.bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = wide_shift[WIDE_W-1:N];
                sh_d  = wide_shift[N-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    bcd_d   = wide_shift[WIDE_W-1:N];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.bcd   = bcd_q;
    assign bus.count = cnt_q;

`ifdef BIN2BCD_7SEG_EN
    function automatic logic [SEG_W-1:0] seg_glyph(input logic [DIGIT_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

    generate
        for (genvar s = 0; s < D; s++) begin : g_seg
            assign bus.seg[s*SEG_W +: SEG_W] = seg_glyph(bcd_q[s*DIGIT_W +: DIGIT_W]);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq (N=4/D=2 and N=8/D=3 instances)
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.N(4), .D(2)) ifa ();
    bin2bcd_seq_if #(.N(8), .D(3)) ifb ();

    bin2bcd_seq #(.N(4), .D(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    bin2bcd_seq #(.N(8), .D(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [11:0] to_bcd(input int v);
        int x;
        logic [11:0] r;
        x = v;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion from idle and records what the outputs did
    task automatic conv(input int sel, input int v, output logic [11:0] res,
                        output int busy_cyc, output int done_cnt, output int lat,
                        output int cnt_done, output bit held);
        logic [11:0] prev, cur;
        bit b, d;
        int cn;
        res = '0; busy_cyc = 0; done_cnt = 0; lat = -1; cnt_done = -1; held = 1'b1;
        prev = (sel != 0) ? ifb.bcd : {4'h0, ifa.bcd};
        if (sel == 0) begin
            ifa.bin = v[3:0]; ifa.start = 1'b1;
        end else begin
            ifb.bin = v[7:0]; ifb.start = 1'b1;
        end
        tick();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            b   = (sel != 0) ? ifb.busy : ifa.busy;
            d   = (sel != 0) ? ifb.done : ifa.done;
            cur = (sel != 0) ? ifb.bcd : {4'h0, ifa.bcd};
            cn  = (sel != 0) ? int'(ifb.count) : int'(ifa.count);
            if (b) busy_cyc++;
            if (d) begin
                done_cnt++;
                lat = c - 1;
                res = cur;
                cnt_done = cn;
            end else if (done_cnt == 0 && cur !== prev) begin
                held = 1'b0;
            end
            if (!b && done_cnt > 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", ifa.busy); end
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", ifa.done); end
        checks++; if (ifa.bcd !== 8'h00) begin errors++; $display("FAIL reset_bcd got %h want 00", ifa.bcd); end
        checks++; if (ifa.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ifa.count); end
        checks++; if (ifb.bcd !== 12'h000 || ifb.busy !== 1'b0) begin
            errors++; $display("FAIL reset_b got bcd %h busy %0b want 000 0", ifb.bcd, ifb.busy);
        end
`ifdef BIN2BCD_7SEG_EN
        checks++; if (ifa.seg !== {7'b0111111, 7'b0111111}) begin
            errors++; $display("FAIL reset_seg got %b want both zero glyphs", ifa.seg);
        end
`endif
    endtask

    task automatic test_max();
        logic [11:0] r; int bc, dc, lt, cd; bit h;
        conv(0, 15, r, bc, dc, lt, cd, h);
        checks++; if (r !== 12'h015) begin errors++; $display("FAIL max_bcd got %h want 015", r); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL max_done_count got %0d want 1", dc); end
        checks++; if (lt !== 4) begin errors++; $display("FAIL max_latency got %0d want 4", lt); end
        checks++; if (bc !== 5) begin errors++; $display("FAIL max_busy_cycles got %0d want 5", bc); end
        checks++; if (cd !== 4) begin errors++; $display("FAIL max_count_in_done got %0d want 4", cd); end
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL max_hold got %0b want 1", h); end
    endtask

    task automatic test_zero_then_nine();
        logic [11:0] r; int bc, dc, lt, cd; bit h;
        conv(0, 0, r, bc, dc, lt, cd, h);
        checks++; if (r !== 12'h000) begin errors++; $display("FAIL zero_bcd got %h want 000", r); end
        checks++; if (dc !== 1 || lt !== 4) begin errors++; $display("FAIL zero_done got %0d/%0d want 1/4", dc, lt); end
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL zero_hold got %0b want 1", h); end
        conv(0, 9, r, bc, dc, lt, cd, h);
        checks++; if (r !== 12'h009) begin errors++; $display("FAIL nine_bcd got %h want 009", r); end
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL nine_hold got %0b want 1", h); end
    endtask

    task automatic test_ignore_start();
        int dc;
        logic [7:0] r;
        dc = 0; r = '0;
        ifa.bin = 4'd12; ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        ifa.bin = 4'd3; ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (ifa.done) begin dc++; r = ifa.bcd; end
            tick();
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dc); end
        checks++; if (r !== 8'h12) begin errors++; $display("FAIL ignore_bcd got %h want 12", r); end
        checks++; if (ifa.busy !== 1'b0 || ifa.bcd !== 8'h12) begin
            errors++; $display("FAIL ignore_after got busy %0b bcd %h want 0 12", ifa.busy, ifa.bcd);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] r; int bc, dc, lt, cd; bit h;
        ifa.bin = 4'd15; ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl got busy %0b done %0b want 0 0", ifa.busy, ifa.done);
        end
        checks++; if (ifa.bcd !== 8'h00) begin errors++; $display("FAIL rstmid_bcd got %h want 00", ifa.bcd); end
        checks++; if (ifa.count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", ifa.count); end
        tick();
        rst = 1'b0;
        tick();
        conv(0, 7, r, bc, dc, lt, cd, h);
        checks++; if (r !== 12'h007 || dc !== 1) begin
            errors++; $display("FAIL rstmid_fresh got %h/%0d want 007/1", r, dc);
        end
`ifdef BIN2BCD_7SEG_EN
        checks++; if (ifa.seg[6:0] !== 7'b0000111) begin errors++; $display("FAIL seg_units got %b want 0000111", ifa.seg[6:0]); end
        checks++; if (ifa.seg[13:7] !== 7'b0111111) begin errors++; $display("FAIL seg_tens got %b want 0111111", ifa.seg[13:7]); end
`endif
    endtask

    task automatic test_wide();
        logic [11:0] r; int bc, dc, lt, cd; bit h;
        conv(1, 255, r, bc, dc, lt, cd, h);
        checks++; if (r !== 12'h255) begin errors++; $display("FAIL wide_bcd got %h want 255", r); end
        checks++; if (lt !== 8 || dc !== 1) begin errors++; $display("FAIL wide_done got lat %0d n %0d want 8 1", lt, dc); end
        checks++; if (cd !== 8) begin errors++; $display("FAIL wide_count got %0d want 8", cd); end
        checks++; if (bc !== 9) begin errors++; $display("FAIL wide_busy got %0d want 9", bc); end
    endtask

    task automatic test_random();
        logic [11:0] r; int bc, dc, lt, cd, v; bit h;
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 15));
            conv(0, v, r, bc, dc, lt, cd, h);
            checks++; if (r !== to_bcd(v) || dc !== 1 || lt !== 4 || h !== 1'b1) begin
                errors++; $display("FAIL rand_a v=%0d got %h done %0d lat %0d held %0b want %h 1 4 1", v, r, dc, lt, h, to_bcd(v));
            end
        end
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 255));
            conv(1, v, r, bc, dc, lt, cd, h);
            checks++; if (r !== to_bcd(v) || dc !== 1 || lt !== 8 || h !== 1'b1) begin
                errors++; $display("FAIL rand_b v=%0d got %h done %0d lat %0d held %0b want %h 1 8 1", v, r, dc, lt, h, to_bcd(v));
            end
        end
    endtask

    task automatic test_back_to_back();
        int vals[3];
        int idx, last;
        for (int i = 0; i < 3; i++) vals[i] = int'($urandom_range(0, 15));
        idx = 0; last = -1;
        ifa.bin = vals[0][3:0]; ifa.start = 1'b1;
        tick();
        for (int c = 1; c <= 60; c++) begin
            if (ifa.done) begin
                checks++; if ({4'h0, ifa.bcd} !== to_bcd(vals[idx])) begin
                    errors++; $display("FAIL b2b_bcd idx %0d got %h want %h", idx, ifa.bcd, to_bcd(vals[idx]));
                end
                if (last >= 0) begin
                    checks++; if (c - last !== 6) begin errors++; $display("FAIL b2b_period got %0d want 6", c - last); end
                end
                last = c;
                idx++;
                if (idx == 3) break;
                ifa.bin = vals[idx][3:0];
            end
            tick();
        end
        ifa.start = 1'b0;
        tick();
        tick();
        checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_conversions got %0d want 3", idx); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %0b want 0", ifa.busy); end
    endtask

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifa.bin = '0;
        ifb.start = 1'b0; ifb.bin = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_max();
        test_zero_then_nine();
        test_ignore_start();
        test_reset_mid();
        test_wide();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly downstream of the restoring divider. It captures the divider's quotient or remainder on a `start` pulse and produces packed BCD digits for display. It drives a one-cycle `done` pulse and holds the result stable until the next conversion completes.

## Interface
**Parameters**
- `N`, default 4: binary input width; matches the divider's `N`.
- `D`, default 2: number of BCD digits. Must satisfy 10^D > 2^N − 1. Violation is a configuration error.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request conversion of `bin`. Sampled only in IDLE.
- `bin`, input, N: binary value, normally the divider's `regQ`. Sampled on the accepted `start` edge only.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `done`, output, 1: one-cycle pulse, high only in DONE.
- `bcd`, output, 4·D: result. Digit i occupies bits [4i+3:4i]; digit 0 is the units digit.
- `count`, output, $clog2(N+1): number of shift iterations completed.
- `seg`, output, 7·D: present only with `BIN2BCD_7SEG_EN`. See Configuration.

## Operation
- Internal registers:
  - binary shift register `sh` (N bits)
  - BCD scratch register `acc` (4·D bits)
  - output register `bcd_q` (4·D bits); `bcd = bcd_q`
  - iteration counter `cnt`; `count = cnt`
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `start = 1`: `sh ← bin`, `acc ← 0`, `cnt ← 0`, go to SHIFT.
  - Otherwise: hold.
- **SHIFT**, each cycle:
  - Every digit of `acc` that is ≥ 5 gets +3; the other digits are unchanged. Call the result `acc'`.
  - Then `{acc, sh} ← {acc', sh} << 1`. `acc[0]` receives the old `sh[N-1]`.
  - `cnt ← cnt + 1`.
  - When `cnt` reaches N (the transition from N−1 to N), `bcd_q ←` the shifted `acc` value in the same edge, and go to DONE.
- **DONE**: `done = 1`. Unconditionally go to IDLE on the next edge.
- `start` is ignored while `busy = 1`. There is no queuing.
- `start` held high continuously: a new conversion begins on each return to IDLE, so one conversion runs every N+2 cycles.
- `bcd_q` changes only on the final SHIFT edge. It is never exposed mid-conversion.
- Arithmetic:
  - The add-3 is 4-bit and never overflows, because digits are ≤ 9 before the adjust.
  - Carry out of the top digit is impossible under the D constraint and is discarded.
- Reset values: state IDLE, `busy = 0`, `done = 0`, `bcd = 0`, `count = 0`, `sh = 0`, `acc = 0`. With the macro defined, `seg` shows digit 0 on every position.
- Reset asserted mid-conversion aborts immediately. `bcd` returns to 0 and is not preserved.

## Timing
- `start` is accepted at edge k. SHIFT iterations occur at edges k+1 … k+N.
- `done` and the new `bcd` are visible in the cycle after edge k+N, which is N cycles after acceptance.
- `busy` is high from after edge k through the DONE cycle, i.e. N+1 cycles in total.
- `bin` may change freely after edge k.

## Configuration
- `BIN2BCD_7SEG_EN` defined:
  - Adds the `seg` output, computed combinationally from `bcd_q`.
  - Digit i drives `seg[7i+6:7i]`, active-high, bit order gfedcba.
  - Values 0–9 map to standard glyphs. Codes 10–15 are unreachable and drive all-off.
- Macro undefined: the `seg` port and the decoder do not exist. All other behaviour is identical.

## Structure
- Shared package `bcd_pkg`:
  - state enum (IDLE, SHIFT, DONE)
  - `DIGIT_W = 4`
  - `SEG_W = 7`
  - 7-segment glyph constants for 0–9
- Sub-module `bcd_add3`: one 4-bit combinational cell (in ≥ 5 → in+3, else in), instantiated D times by generate.
- FSM, counter and registers stay in the top module.
- The 7-segment decoder is an inline function guarded by the macro.

## Test plan
- N=4, D=2, `bin=15`, `start` pulsed at edge k: `done` is high in the cycle after edge k+4, `bcd = 8'h15`, `busy` is high 5 cycles.
- N=4, `bin=0`: `bcd = 8'h00`, `done` pulse after 4 iterations. Then `bin=9`: `bcd = 8'h09`. The previous result is held until the final edge.
- `start` re-pulsed during SHIFT with `bin=3`, while converting 12: the second request is ignored, result `8'h12`, exactly one `done`.
- `rst` raised at iteration 2 while converting 15: outputs are immediately 0 and state is IDLE. A fresh `start` with `bin=7` then gives `8'h07`.
- N=8, D=3, `bin=255`: `bcd = 12'h255` after 8 iterations, `count = 8` in DONE.
- With `BIN2BCD_7SEG_EN`, `bin=7`: `seg[6:0] = 7'b0000111` and `seg[13:7] = 7'b0111111`.
